prco_lsu: RTL and testbench
===========================

# prco_lsu

Load/store unit that consumes the ALU's RAM-enable pulse together with the computed effective address and executes the LW/SW access against the data RAM over a req/ack handshake. It sits between the ALU stage and the register-file writeback port. It returns loaded data as a one-cycle register-write pulse and signals completion of every access. It also bounds RAM wait states with a timeout.

## Interface
- TIMEOUT, 15: max cycles q_mem_req may stay high without i_mem_ack before abort; legal range 1..255.
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_ce  in  1  one-cycle start strobe (ALU RAM enable)
- i_op  in  5  opcode, `PRCO_OP_LW or `PRCO_OP_SW from the ISA definitions
- i_addr  in  16  effective address (ALU result)
- i_wdata  in  16  store data
- i_rd  in  3  destination register index for LW
- q_busy  out  1  high while a transaction is in flight
- q_mem_req  out  1  RAM request, held until ack or timeout
- q_mem_we  out  1  1 = write (SW), 0 = read (LW)
- q_mem_addr  out  16  RAM address
- q_mem_wdata  out  16  RAM write data
- i_mem_ack  in  1  RAM acknowledge, one-cycle pulse
- i_mem_rdata  in  16  read data, valid in the i_mem_ack cycle
- q_ce_reg  out  1  one-cycle register-write strobe (LW only)
- q_rd  out  3  register index accompanying q_ce_reg
- q_result  out  16  loaded data accompanying q_ce_reg
- q_done  out  1  one-cycle completion pulse, every accepted transaction
- q_err  out  1  one-cycle error pulse

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: on i_ce=1, latch i_op/i_addr/i_wdata/i_rd; q_mem_addr<=i_addr, q_mem_wdata<=i_wdata, q_mem_we<=(op==SW), q_mem_req<=1, q_busy<=1, counter<=0, go REQ.
- i_ce in IDLE with op not LW/SW: no RAM access, q_err pulse next cycle, q_done not asserted, stay IDLE.
- REQ: counter increments each cycle. On i_mem_ack=1: q_mem_req<=0; for LW q_result<=i_mem_rdata, q_rd<=latched rd, q_ce_reg<=1; q_done<=1; go DONE.
- REQ timeout: counter reaches TIMEOUT-1 with no ack -> q_mem_req<=0, q_err<=1, q_done<=1, no q_ce_reg, go DONE.
- Ack and timeout in the same cycle: ack wins, normal completion, no q_err.
- DONE: clear q_ce_reg/q_done/q_err, q_busy<=0, go IDLE (one cycle).
- i_ce while q_busy=1: request dropped, q_err pulse, in-flight transaction unaffected. If this coincides with an ack or timeout, q_err is high in that same completion cycle.
- i_mem_ack while q_mem_req=0: ignored.
- q_result and q_rd hold their last value between loads; SW never changes them.
- Widths: address and data pass through unmodified, no arithmetic.

## Timing
- Reset values: all outputs 0. FSM=IDLE, counter=0, latched fields 0.
- Reset mid-transaction: q_mem_req and all strobes drop asynchronously. The in-flight access is lost with no q_done.
- i_ce at edge N -> q_mem_req=1 after edge N.
- Ack sampled at edge M -> q_mem_req=0, q_ce_reg/q_done=1 after edge M, cleared after edge M+1.
- Zero-wait RAM (ack in the first REQ cycle) gives 2 cycles from i_ce to q_done.
- Back-to-back issue throughput is one access per 3 cycles; a new i_ce is accepted at the edge after q_busy falls.
- All strobes are exactly one cycle wide.

## Test plan
- LW, i_addr=0x0040, i_rd=3, ack on the 3rd REQ cycle with rdata=0xBEEF -> q_mem_req high 3 cycles, q_mem_we=0; q_ce_reg, q_done one cycle with q_rd=3, q_result=0xBEEF.
- SW, i_addr=0xFFFF, i_wdata=0x1234, ack immediately -> q_mem_we=1, q_mem_addr=0xFFFF, q_mem_wdata=0x1234; q_done pulse 2 cycles after i_ce; q_ce_reg stays 0; q_result unchanged.
- LW with no ack, TIMEOUT=15 -> q_mem_req high exactly 15 cycles; q_err and q_done pulse together; no q_ce_reg. A repeat test with ack on cycle 15 -> normal completion, q_err=0.
- i_ce pulse during REQ of a LW -> q_err pulse; the first LW completes normally; the second op never reaches RAM.
- Unknown op (NOP) with i_ce=1 -> q_err pulse, q_mem_req stays 0, q_done stays 0.
- Assert i_reset during REQ of an SW -> q_mem_req falls without waiting for a clock edge; all outputs 0; a subsequent LW completes correctly.

Source files
------------

// File: rtl/prco_lsu.sv
// Load/store unit: turns the ALU RAM-enable pulse into one LW/SW access over a
// req/ack handshake, with a bounded wait and one-cycle result/done/err strobes.
module prco_lsu #(
   parameter int           TIMEOUT = 15,
   parameter logic [4:0]   OP_LW   = 5'h0C,
   parameter logic [4:0]   OP_SW   = 5'h0D
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ce,
   input  logic [4:0]  i_op,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_wdata,
   input  logic [2:0]  i_rd,
   output logic        q_busy,
   output logic        q_mem_req,
   output logic        q_mem_we,
   output logic [15:0] q_mem_addr,
   output logic [15:0] q_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [15:0] i_mem_rdata,
   output logic        q_ce_reg,
   output logic [2:0]  q_rd,
   output logic [15:0] q_result,
   output logic        q_done,
   output logic        q_err
);

   // Handshake: q_mem_req rises after the accepting edge and stays high until
   // the edge that samples i_mem_ack=1 or the wait budget runs out; an ack
   // seen while q_mem_req=0 is ignored.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic [7:0] count;
   logic [4:0] op;
   logic [2:0] rd;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= S_IDLE;
         count       <= 8'd0;
         op          <= 5'd0;
         rd          <= 3'd0;
         q_busy      <= 1'b0;
         q_mem_req   <= 1'b0;
         q_mem_we    <= 1'b0;
         q_mem_addr  <= 16'd0;
         q_mem_wdata <= 16'd0;
         q_ce_reg    <= 1'b0;
         q_rd        <= 3'd0;
         q_result    <= 16'd0;
         q_done      <= 1'b0;
         q_err       <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-armed below.
         q_ce_reg <= 1'b0;
         q_done   <= 1'b0;
         q_err    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_ce) begin
                  if (i_op == OP_LW || i_op == OP_SW) begin
                     op          <= i_op;
                     rd          <= i_rd;
                     q_mem_addr  <= i_addr;
                     q_mem_wdata <= i_wdata;
                     q_mem_we    <= (i_op == OP_SW);
                     q_mem_req   <= 1'b1;
                     q_busy      <= 1'b1;
                     count       <= 8'd0;
                     state       <= S_REQ;
                  end else begin
                     q_err <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               // A start strobe while busy is dropped but flagged.
               if (i_ce) begin
                  q_err <= 1'b1;
               end
               if (i_mem_ack) begin
                  q_mem_req <= 1'b0;
                  if (op == OP_LW) begin
                     q_result <= i_mem_rdata;
                     q_rd     <= rd;
                     q_ce_reg <= 1'b1;
                  end
                  q_done <= 1'b1;
                  state  <= S_DONE;
               end else if (count == LAST_WAIT) begin
                  q_mem_req <= 1'b0;
                  q_err     <= 1'b1;
                  q_done    <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  count <= count + 8'd1;
               end
            end
            S_DONE: begin
               if (i_ce) begin
                  q_err <= 1'b1;
               end
               q_busy <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prco_lsu.sv
// Bench for prco_lsu: directed scenarios followed by randomized LW/SW traffic,
// each transaction checked against a transaction-level model of the unit.
module tb_prco_lsu;

   localparam int         TIMEOUT = 15;
   localparam logic [4:0] OP_LW   = 5'h0C;
   localparam logic [4:0] OP_SW   = 5'h0D;
   localparam logic [4:0] OP_NOP  = 5'h00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_ce = 1'b0;
   logic [4:0]  i_op = '0;
   logic [15:0] i_addr = '0;
   logic [15:0] i_wdata = '0;
   logic [2:0]  i_rd = '0;
   logic        i_mem_ack = 1'b0;
   logic [15:0] i_mem_rdata = '0;
   logic        q_busy, q_mem_req, q_mem_we, q_ce_reg, q_done, q_err;
   logic [15:0] q_mem_addr, q_mem_wdata, q_result;
   logic [2:0]  q_rd;

   prco_lsu #(.TIMEOUT(TIMEOUT), .OP_LW(OP_LW), .OP_SW(OP_SW)) dut (
      .i_clk(clk), .i_reset(rst), .i_ce(i_ce), .i_op(i_op), .i_addr(i_addr),
      .i_wdata(i_wdata), .i_rd(i_rd), .q_busy(q_busy), .q_mem_req(q_mem_req),
      .q_mem_we(q_mem_we), .q_mem_addr(q_mem_addr), .q_mem_wdata(q_mem_wdata),
      .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .q_ce_reg(q_ce_reg),
      .q_rd(q_rd), .q_result(q_result), .q_done(q_done), .q_err(q_err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_result = '0;
   logic [2:0]  exp_rd = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {7'd0, q_busy, q_mem_req, q_mem_we, q_mem_addr, q_mem_wdata,
              q_ce_reg, q_rd, q_result, q_done, q_err};
   endfunction

   // One LW/SW: ack_cycle = REQ cycle carrying the ack (0 = none, >TIMEOUT = too late),
   // ce_during = REQ cycle in which a second start strobe is driven (0 = none).
   task automatic txn(input logic [4:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [2:0] rd, input int ack_cycle, input logic [15:0] rdata,
                      input int ce_during);
      int   end_c, exp_err_n;
      bit   acked, is_lw;
      int   req_n = 0, busy_n = 0, done_n = 0, done_at = 0, ce_n = 0, err_n = 0;
      is_lw = (op == OP_LW);
      acked = (ack_cycle >= 1) && (ack_cycle <= TIMEOUT);
      end_c = acked ? ack_cycle : TIMEOUT;
      exp_err_n = (acked ? 0 : 1) + (ce_during > 0 ? 1 : 0)
                  - ((!acked && ce_during == end_c) ? 1 : 0);
      if (is_lw && acked) begin
         exp_q.push_back(rdata);
         exp_result = rdata;
         exp_rd     = rd;
      end
      @(negedge clk);
      i_ce = 1'b1; i_op = op; i_addr = addr; i_wdata = wdata; i_rd = rd;
      for (int c = 1; c <= TIMEOUT + 3; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("mem_we", q_mem_we, op == OP_SW);
            chk("mem_wdata", q_mem_wdata, wdata);
         end
         if (q_mem_req) begin
            req_n++;
            chk("mem_addr", q_mem_addr, addr);
         end
         if (q_busy) busy_n++;
         if (q_err) err_n++;
         if (q_done) begin
            done_n++;
            done_at = c;
            chk("err_at_done", q_err, !acked || ce_during == end_c);
         end
         if (q_ce_reg) begin
            ce_n++;
            if (exp_q.size() > 0) begin
               chk("result", q_result, exp_q.pop_front());
               chk("rd", q_rd, rd);
            end
         end
         i_mem_ack   = (c == ack_cycle);
         i_mem_rdata = (c == ack_cycle) ? rdata : 16'($urandom);
         i_ce        = (c == ce_during);
         i_op        = OP_SW;
         i_addr      = ~addr;
      end
      i_ce = 1'b0; i_mem_ack = 1'b0;
      chk("req_cycles", req_n, end_c);
      chk("busy_cycles", busy_n, end_c + 1);
      chk("done_count", done_n, 1);
      chk("done_latency", done_at, end_c + 1);
      chk("ce_reg_count", ce_n, (is_lw && acked) ? 1 : 0);
      chk("err_count", err_n, exp_err_n);
      chk("result_hold", q_result, exp_result);
      chk("rd_hold", q_rd, exp_rd);
      chk("exp_q_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic bad_op(input logic [4:0] op);
      int err_n = 0, req_n = 0, done_n = 0, busy_n = 0;
      @(negedge clk);
      i_ce = 1'b1; i_op = op; i_addr = 16'($urandom);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         i_ce = 1'b0;
         if (q_err) err_n++;
         if (q_mem_req) req_n++;
         if (q_done) done_n++;
         if (q_busy) busy_n++;
      end
      chk("badop_err", err_n, 1);
      chk("badop_req", req_n, 0);
      chk("badop_done", done_n, 0);
      chk("badop_busy", busy_n, 0);
   endtask

   initial begin
      int ack, endc, ce;
      logic [4:0] op;
      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", all_outs(), 64'd0);
      rst = 1'b0;

      txn(OP_LW, 16'h0040, 16'h0000, 3'd3, 3, 16'hBEEF, 0);
      txn(OP_SW, 16'hFFFF, 16'h1234, 3'd5, 1, 16'h5555, 0);
      txn(OP_LW, 16'h0100, 16'h0000, 3'd6, 0, 16'hAAAA, 0);
      txn(OP_LW, 16'h0102, 16'h0000, 3'd7, TIMEOUT, 16'hC0DE, 0);
      txn(OP_LW, 16'h0200, 16'h0000, 3'd1, 4, 16'h1357, 2);
      txn(OP_SW, 16'h0300, 16'h9999, 3'd2, 2, 16'h0000, 2);
      txn(OP_LW, 16'h0400, 16'h0000, 3'd4, 0, 16'h0000, TIMEOUT);
      bad_op(OP_NOP);

      // Reset in the middle of an SW request
      @(negedge clk);
      i_ce = 1'b1; i_op = OP_SW; i_addr = 16'h0AAA; i_wdata = 16'h7777;
      @(negedge clk);
      i_ce = 1'b0;
      @(negedge clk);
      chk("pre_reset_req", q_mem_req, 1'b1);
      #2 rst = 1'b1;
      #1 chk("async_reset_req", q_mem_req, 1'b0);
      chk("async_reset_outputs", all_outs(), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_result = '0;
      exp_rd     = '0;
      txn(OP_LW, 16'h0042, 16'h0000, 3'd2, 2, 16'hFACE, 0);

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            bad_op(5'($urandom_range(0, 11)));
         end else begin
            op   = $urandom_range(0, 1) ? OP_LW : OP_SW;
            ack  = $urandom_range(0, TIMEOUT + 2);
            endc = (ack >= 1 && ack <= TIMEOUT) ? ack : TIMEOUT;
            ce   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, endc) : 0;
            txn(op, 16'($urandom), 16'($urandom), 3'($urandom), ack, 16'($urandom), ce);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
